// File: rtl/gate_pipe_pkg.sv
// Shared constants for the gate_pipe block: op encodings and parameter limits.
package gate_pipe_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam int unsigned MAX_STAGES = 4;
  localparam int unsigned MAX_WIDTH  = 64;

endpackage

// File: rtl/gate_pipe_stage.sv
// One pipeline slot of gate_pipe: a data register plus valid bit that loads when
// told to and otherwise holds.
module gate_pipe_stage
  import gate_pipe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // An empty slot may be loaded too; its data bits then simply go stale.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = in_valid;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/gate_pipe.sv
// Pipelined bitwise gate (AND/OR/XOR/NAND) with valid/ready on both sides and an
// output-transfer counter. Define GATE_PIPE_ZERO_FLAG_EN to add a result-is-zero flag.
module gate_pipe
  import gate_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt
`ifdef GATE_PIPE_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  if (WIDTH == 0 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("gate_pipe: WIDTH out of range");
  end
  if (STAGES == 0 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("gate_pipe: STAGES out of range");
  end

`ifdef GATE_PIPE_ZERO_FLAG_EN
  localparam int unsigned DW = WIDTH + 1;
`else
  localparam int unsigned DW = WIDTH;
`endif

  logic [WIDTH-1:0]  result;
  logic [DW-1:0]     stage_in;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] load;
  logic [DW-1:0]     din  [STAGES];
  logic [DW-1:0]     data [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              all_full;

  always_comb begin
    result = '0;
    unique case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      default: result = '0;
    endcase
  end

`ifdef GATE_PIPE_ZERO_FLAG_EN
  assign stage_in = {(result == '0), result};
`else
  assign stage_in = result;
`endif

  // Stage k may load unless it and every stage after it is full with the sink stalled.
  // Written in closed form so the ready chain has no combinational self-reference.
  always_comb begin
    all_full = 1'b1;
    load     = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      all_full = all_full & valid[k];
      load[k]  = out_ready | ~all_full;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vin[k] = in_valid;
      assign din[k] = stage_in;
    end else begin : g_body
      assign vin[k] = valid[k-1];
      assign din[k] = data[k-1];
    end

    gate_pipe_stage #(
      .W(DW)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .in_valid (vin[k]),
      .in_data  (din[k]),
      .out_valid(valid[k]),
      .out_data (data[k])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid[STAGES-1];
  assign s         = data[STAGES-1][WIDTH-1:0];
  assign xfer_cnt  = cnt_q;
`ifdef GATE_PIPE_ZERO_FLAG_EN
  assign zero      = data[STAGES-1][WIDTH];
`endif

endmodule
